calendar_date_counter: RTL
==========================

Name: calendar_date_counter

Overview:
- Keeps the running calendar date (year, month, day, weekday) for the clock/calendar display path.
- Advances the date by one day per `tick` pulse.
- Contains internal days-in-month logic with the correct leap rule, and validates software date loads through a req/ack handshake.
- Sits between the seconds/minutes/hours chain (source of `tick` at midnight) and the display formatter.

Parameters:
- YEAR_W, 7, width of year field; year encodes 2000+year, legal range 0..99.
- RESET_WDAY, 6, weekday at reset (0=Sunday; 2000-01-01 is Saturday).

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- tick  input  1  one-cycle pulse: advance date by one day
- set_req  input  1  load request, held high until set_ack seen
- set_year  input  YEAR_W  requested year (0..99)
- set_month  input  4  requested month (1..12)
- set_day  input  5  requested day (1..days-in-month)
- set_wday  input  3  requested weekday (0..6)
- set_ack  output  1  one-cycle pulse: load request completed
- set_err  output  1  valid with set_ack: 1 = request rejected, date unchanged
- year  output  YEAR_W  current year
- month  output  4  current month 1..12
- day  output  5  current day 1..31
- wday  output  3  current weekday 0..6
- month_end  output  1  one-cycle pulse when day wraps to 1
- year_end  output  1  one-cycle pulse when Dec 31 wraps to Jan 1

Behaviour:
- Reset (rst=1 at edge): year=0, month=1, day=1, wday=RESET_WDAY, set_ack=0, set_err=0, month_end=0, year_end=0, state=RUN, pending=0. rst has priority over all inputs.
- Days-in-month (dim):
  - 31 for months 1,3,5,7,8,10,12; 30 for 4,6,9,11.
  - Feb: 29 if year[1:0]==0, else 28. Exact for 2000..2099.
  - Illegal month gives dim=0.
- Advance (tick=1 in RUN), registered with 1-cycle latency, new values visible the cycle after the tick edge:
  - wday = (wday==6) ? 0 : wday+1.
  - If day<dim(year,month): day+1.
  - Else: day=1 and month_end=1. If month<12, month+1. Else month=1, year = (year==99) ? 0 : year+1, and year_end=1.
  - month_end/year_end are high exactly one cycle; both are set together at year rollover.
- FSM states: RUN, CHECK, ACK, WAIT_REL.
  - RUN: set_req=1 registers set_* into shadow regs and goes to CHECK. A tick in the same cycle is applied to the current date before the load.
  - CHECK (1 cycle): validate shadow against month 1..12, day 1..dim(shadow year, shadow month), wday<=6, year<=99. Store result, then go to ACK. A tick here sets pending=1.
  - ACK (1 cycle):
    - set_ack=1.
    - If valid: load date from shadow, set_err=0, and discard pending (the loaded date is authoritative).
    - If invalid: set_err=1, date unchanged, and apply one pending advance in this cycle.
    - A tick arriving in ACK itself is also recorded in pending.
    - Then go to WAIT_REL.
  - WAIT_REL: apply any pending advance in the first cycle, then clear pending. Advance on new ticks normally. Go to RUN when set_req=0, so a held-high req never re-triggers.
- Timing: set_req first high at cycle N gives set_ack at cycle N+2, with the new date visible at N+3. set_err is 0 whenever set_ack=0.
- At most one pending advance is held. `tick` is guaranteed at most once per 3 cycles, so no ticks are lost.
- Reset mid-handshake: the FSM returns to RUN, the shadow regs are discarded, and no set_ack is issued.

Test Plan:
- Reset, then 1 tick -> year=0, month=1, day=2, wday=0; no end pulses.
- Load 23/2/28 wday=2 (accepted), then tick -> 23/3/1, wday=3, month_end=1 for one cycle. Load 24/2/28, tick -> 24/2/29; tick -> 24/3/1.
- Load 99/12/31 wday=4, tick -> 0/1/1, wday=5, month_end=1 and year_end=1 in the same cycle.
- Load 23/2/29 -> set_ack with set_err=1, date unchanged. Load month=13 or day=0 -> set_err=1. Load 24/4/30 -> set_err=0.
- Hold set_req high 10 cycles -> exactly one set_ack, at N+2. Tick during CHECK with an invalid load -> date advances once. Tick during CHECK with a valid load -> loaded date shown un-advanced.
- Assert rst in the CHECK state -> no set_ack; date = 0/1/1, wday=6 the next cycle.

Source files
------------

// File: rtl/calendar_date_counter.sv
// Running calendar date (2000..2099 plus weekday), advanced one day per tick, with validated software loads.
// Advance visible 1 cycle after tick; load ack 2 cycles after set_req rises, a held set_req never re-triggers.
module calendar_date_counter #(
  parameter int YEAR_W     = 7,
  parameter int RESET_WDAY = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick,
  input  logic              set_req,
  input  logic [YEAR_W-1:0] set_year,
  input  logic [3:0]        set_month,
  input  logic [4:0]        set_day,
  input  logic [2:0]        set_wday,
  output logic              set_ack,
  output logic              set_err,
  output logic [YEAR_W-1:0] year,
  output logic [3:0]        month,
  output logic [4:0]        day,
  output logic [2:0]        wday,
  output logic              month_end,
  output logic              year_end
);

  typedef enum logic [1:0] {RUN, CHECK, ACK, WAIT_REL} state_t;

  localparam logic [YEAR_W-1:0] LP_YEAR_MAX   = YEAR_W'(99);
  localparam logic [2:0]        LP_RESET_WDAY = 3'(RESET_WDAY);

  state_t            r_state;
  logic [YEAR_W-1:0] r_year;
  logic [3:0]        r_month;
  logic [4:0]        r_day;
  logic [2:0]        r_wday;
  logic [YEAR_W-1:0] r_sh_year;
  logic [3:0]        r_sh_month;
  logic [4:0]        r_sh_day;
  logic [2:0]        r_sh_wday;
  logic              r_pending;
  logic              r_valid;
  logic              r_set_ack;
  logic              r_set_err;
  logic              r_month_end;
  logic              r_year_end;

  logic [4:0]        w_dim_cur;
  logic [4:0]        w_dim_sh;
  logic [YEAR_W-1:0] w_nxt_year;
  logic [3:0]        w_nxt_month;
  logic [4:0]        w_nxt_day;
  logic [2:0]        w_nxt_wday;
  logic              w_wrap_month;
  logic              w_wrap_year;
  logic              w_sh_valid;
  logic              w_adv;
  logic              w_load;

  // Divisible-by-4 leap rule is exact across 2000..2099 (2000 itself is a leap year).
  function automatic logic [4:0] f_dim(input logic [YEAR_W-1:0] yr, input logic [3:0] mo);
    case (mo)
      4'd1, 4'd3, 4'd5, 4'd7, 4'd8, 4'd10, 4'd12: f_dim = 5'd31;
      4'd4, 4'd6, 4'd9, 4'd11:                    f_dim = 5'd30;
      4'd2:    f_dim = (yr[1:0] == 2'b00) ? 5'd29 : 5'd28;
      default: f_dim = 5'd0;
    endcase
  endfunction

  always_comb begin
    w_dim_cur    = f_dim(r_year, r_month);
    w_nxt_year   = r_year;
    w_nxt_month  = r_month;
    w_nxt_day    = r_day + 5'd1;
    w_nxt_wday   = (r_wday == 3'd6) ? 3'd0 : r_wday + 3'd1;
    w_wrap_month = 1'b0;
    w_wrap_year  = 1'b0;
    if (r_day >= w_dim_cur) begin
      w_nxt_day    = 5'd1;
      w_wrap_month = 1'b1;
      if (r_month < 4'd12) begin
        w_nxt_month = r_month + 4'd1;
      end else begin
        w_nxt_month = 4'd1;
        w_nxt_year  = (r_year == LP_YEAR_MAX) ? '0 : r_year + 1'b1;
        w_wrap_year = 1'b1;
      end
    end
  end

  always_comb begin
    w_dim_sh   = f_dim(r_sh_year, r_sh_month);
    w_sh_valid = (r_sh_month >= 4'd1) && (r_sh_month <= 4'd12) &&
                 (r_sh_day != 5'd0) && (r_sh_day <= w_dim_sh) &&
                 (r_sh_wday <= 3'd6) && (r_sh_year <= LP_YEAR_MAX);
  end

  // A tick seen during CHECK/ACK is parked in r_pending and replayed after the ack.
  always_comb begin
    w_load = (r_state == ACK) && r_valid;
    case (r_state)
      RUN:      w_adv = tick;
      CHECK:    w_adv = 1'b0;
      ACK:      w_adv = !r_valid && r_pending;
      WAIT_REL: w_adv = tick || r_pending;
      default:  w_adv = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= RUN;
      r_year      <= '0;
      r_month     <= 4'd1;
      r_day       <= 5'd1;
      r_wday      <= LP_RESET_WDAY;
      r_sh_year   <= '0;
      r_sh_month  <= '0;
      r_sh_day    <= '0;
      r_sh_wday   <= '0;
      r_pending   <= 1'b0;
      r_valid     <= 1'b0;
      r_set_ack   <= 1'b0;
      r_set_err   <= 1'b0;
      r_month_end <= 1'b0;
      r_year_end  <= 1'b0;
    end else begin
      r_set_ack   <= 1'b0;
      r_set_err   <= 1'b0;
      r_month_end <= 1'b0;
      r_year_end  <= 1'b0;

      if (w_load) begin
        r_year  <= r_sh_year;
        r_month <= r_sh_month;
        r_day   <= r_sh_day;
        r_wday  <= r_sh_wday;
      end else if (w_adv) begin
        r_year      <= w_nxt_year;
        r_month     <= w_nxt_month;
        r_day       <= w_nxt_day;
        r_wday      <= w_nxt_wday;
        r_month_end <= w_wrap_month;
        r_year_end  <= w_wrap_year;
      end

      case (r_state)
        RUN: begin
          if (set_req) begin
            r_sh_year  <= set_year;
            r_sh_month <= set_month;
            r_sh_day   <= set_day;
            r_sh_wday  <= set_wday;
            r_state    <= CHECK;
          end
        end
        CHECK: begin
          r_valid   <= w_sh_valid;
          r_set_ack <= 1'b1;
          r_set_err <= !w_sh_valid;
          if (tick) r_pending <= 1'b1;
          r_state   <= ACK;
        end
        ACK: begin
          // A valid load supersedes any parked advance; only a tick arriving now survives.
          r_pending <= tick;
          r_state   <= WAIT_REL;
        end
        WAIT_REL: begin
          r_pending <= 1'b0;
          if (!set_req) r_state <= RUN;
        end
        default: r_state <= RUN;
      endcase
    end
  end

  assign set_ack   = r_set_ack;
  assign set_err   = r_set_err;
  assign year      = r_year;
  assign month     = r_month;
  assign day       = r_day;
  assign wday      = r_wday;
  assign month_end = r_month_end;
  assign year_end  = r_year_end;

endmodule
